// File: rtl/axis_crc_filter_if.sv
// AXIS_Bus: minimal AXI-Stream bundle shared by the CRC filter ports.
//   tvalid  source -> sink  beat valid
//   tready  sink -> source  beat accepted when tvalid & tready
//   tdata   source -> sink  DW-bit payload
//   tlast   source -> sink  last beat of a packet
interface AXIS_Bus #(
  parameter int DW = 8
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_crc_filter.sv
// axis_crc_filter: store-and-forward AXI-Stream CRC filter with a
// packet-commit FIFO. Beats are written as they arrive; a packet becomes
// visible to the read side only once its tlast beat resolves it as good
// (or bad with DROP_BAD=0). Bad or overflowing packets are rewound away.
//
// Ports:
//   CLK_I        clock, rising edge
//   RST_I        synchronous reset, active-high
//   AXIS_SLV_IF  input stream (never backpressures after reset)
//   AXIS_MST_IF  output stream, one registered beat, 1 beat/clk
//   M_TERR_O     CRC error flag, qualified by master tvalid & tlast
//   GOOD_CNT_O   saturating count of good packets committed
//   BAD_CNT_O    saturating count of packets with non-zero residue
//   OVF_CNT_O    saturating count of packets lost to FIFO overflow
module axis_crc_filter #(
  parameter int               FIFO_DEPTH = 1024,
  parameter int               CRC_W      = 8,
  parameter logic [CRC_W-1:0] CRC_POLY   = 8'h07,
  parameter logic [CRC_W-1:0] CRC_INIT   = 8'hFF,
  parameter bit               DROP_BAD   = 1'b1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  AXIS_Bus.slave      AXIS_SLV_IF,
  AXIS_Bus.master     AXIS_MST_IF,
  output logic        M_TERR_O,
  output logic [31:0] GOOD_CNT_O,
  output logic [31:0] BAD_CNT_O,
  output logic [31:0] OVF_CNT_O
);

  localparam int DW = $bits(AXIS_SLV_IF.tdata);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + 2;  // {err, tlast, tdata}

  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DISCARD} state_t;

  // MSB-first bitwise LFSR over the whole beat; implicit top bit of the poly.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                input logic [DW-1:0]    data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = (c << 1) ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 32'd1 : v;
  endfunction

  state_t           state_q, state_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             commit_ptr_q, commit_ptr_d;
  ptr_t             rd_ptr_q;
  logic [CRC_W-1:0] crc_q, crc_next;
  logic             s_ready_q;
  logic             accept, full, drop_beat, crc_ok;
  logic             wr_en, wr_err, good_inc, bad_inc, ovf_inc;

  logic [EW-1:0]    mem [FIFO_DEPTH];

  logic             out_valid_q, out_last_q, out_err_q;
  logic [DW-1:0]    out_data_q;
  logic             load;

  assign accept   = AXIS_SLV_IF.tvalid & s_ready_q;
  assign crc_next = crc_step(crc_q, AXIS_SLV_IF.tdata);
  assign crc_ok   = (crc_next == '0);

  // Occupancy uses rd_ptr before this cycle's read: conservative by one beat.
  assign full      = (ptr_t'(wr_ptr_q - rd_ptr_q) == ptr_t'(FIFO_DEPTH));
  assign drop_beat = (state_q == ST_DISCARD) || full;

  // Receive FSM: resolves each packet on its tlast beat.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    wr_err       = 1'b0;
    good_inc     = 1'b0;
    bad_inc      = 1'b0;
    ovf_inc      = 1'b0;
    if (accept) begin
      if (drop_beat) begin
        // Overflowed packet: swallow the rest, then drop back to the last commit.
        if (AXIS_SLV_IF.tlast) begin
          wr_ptr_d = commit_ptr_q;
          ovf_inc  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_DISCARD;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (AXIS_SLV_IF.tlast) begin
          state_d = ST_IDLE;
          if (crc_ok) begin
            commit_ptr_d = wr_ptr_q + ptr_t'(1);
            good_inc     = 1'b1;
          end else if (DROP_BAD) begin
            wr_ptr_d = commit_ptr_q;
            bad_inc  = 1'b1;
          end else begin
            commit_ptr_d = wr_ptr_q + ptr_t'(1);
            wr_err       = 1'b1;
            bad_inc      = 1'b1;
          end
        end else begin
          state_d = ST_PKT;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      crc_q        <= CRC_INIT;
      s_ready_q    <= 1'b0;
      GOOD_CNT_O   <= '0;
      BAD_CNT_O    <= '0;
      OVF_CNT_O    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      s_ready_q    <= 1'b1;
      if (accept) begin
        crc_q <= AXIS_SLV_IF.tlast ? CRC_INIT : crc_next;
      end
      GOOD_CNT_O <= sat_inc(GOOD_CNT_O, good_inc);
      BAD_CNT_O  <= sat_inc(BAD_CNT_O, bad_inc);
      OVF_CNT_O  <= sat_inc(OVF_CNT_O, ovf_inc);
    end
  end

  // NOTE: the packet buffer is not reset; pointers alone define which entries are valid.
  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {wr_err, AXIS_SLV_IF.tlast, AXIS_SLV_IF.tdata};
    end
  end

  // Output stage: refills when empty or when its beat is consumed this cycle.
  assign load = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || AXIS_MST_IF.tready);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      {out_err_q, out_last_q, out_data_q} <= mem[rd_ptr_q[AW-1:0]];
      out_valid_q <= 1'b1;
      rd_ptr_q    <= rd_ptr_q + ptr_t'(1);
    end else if (AXIS_MST_IF.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign AXIS_SLV_IF.tready = s_ready_q;
  assign AXIS_MST_IF.tvalid = out_valid_q;
  assign AXIS_MST_IF.tdata  = out_data_q;
  assign AXIS_MST_IF.tlast  = out_last_q;
  assign M_TERR_O           = DROP_BAD ? 1'b0 : out_err_q;

endmodule

// File: tb/tb_axis_crc_filter.sv
// tb_axis_crc_filter: directed bench for axis_crc_filter with a scoreboard.
// Three instances share clock and reset:
//   0: defaults (FIFO_DEPTH=1024, DROP_BAD=1)
//   1: FIFO_DEPTH=4 for overflow handling
//   2: DROP_BAD=0 for error-flag forwarding
// Expected output beats {err&last, last, data} are queued when a packet is
// driven and popped by a negedge monitor at each master handshake.
module tb_axis_crc_filter;

  localparam int N_DUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_tvalid [N_DUT];
  logic        s_tlast  [N_DUT];
  logic [7:0]  s_tdata  [N_DUT];
  logic        m_tready [N_DUT];
  logic        s_tready [N_DUT];
  logic        m_tvalid [N_DUT];
  logic        m_tlast  [N_DUT];
  logic        m_terr   [N_DUT];
  logic [7:0]  m_tdata  [N_DUT];
  logic [31:0] good_cnt [N_DUT];
  logic [31:0] bad_cnt  [N_DUT];
  logic [31:0] ovf_cnt  [N_DUT];

  logic [9:0]  exp_q    [N_DUT][$];
  logic        stall_q  [N_DUT];
  logic [9:0]  held_q   [N_DUT];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    AXIS_Bus #(.DW(8)) slv ();
    AXIS_Bus #(.DW(8)) mst ();

    assign slv.tvalid  = s_tvalid[g];
    assign slv.tdata   = s_tdata[g];
    assign slv.tlast   = s_tlast[g];
    assign s_tready[g] = slv.tready;
    assign mst.tready  = m_tready[g];
    assign m_tvalid[g] = mst.tvalid;
    assign m_tdata[g]  = mst.tdata;
    assign m_tlast[g]  = mst.tlast;

    axis_crc_filter #(
      .FIFO_DEPTH (g == 1 ? 4 : 1024),
      .CRC_W      (8),
      .CRC_POLY   (8'h07),
      .CRC_INIT   (8'hFF),
      .DROP_BAD   (g == 2 ? 1'b0 : 1'b1)
    ) u_dut (
      .CLK_I       (clk),
      .RST_I       (rst),
      .AXIS_SLV_IF (slv),
      .AXIS_MST_IF (mst),
      .M_TERR_O    (m_terr[g]),
      .GOOD_CNT_O  (good_cnt[g]),
      .BAD_CNT_O   (bad_cnt[g]),
      .OVF_CNT_O   (ovf_cnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_of(input int d);
    return {m_terr[d] & m_tlast[d], m_tlast[d], m_tdata[d]};
  endfunction

  // Monitor: scoreboard pops on handshakes, and a stalled beat must hold.
  always @(negedge clk) begin
    for (int d = 0; d < N_DUT; d++) begin
      if (rst) begin
        stall_q[d] <= 1'b0;
      end else begin
        if (stall_q[d]) begin
          check($sformatf("hold_valid_d%0d", d), 32'(m_tvalid[d]), 32'd1);
          check($sformatf("hold_beat_d%0d", d), 32'(obs_of(d)), 32'(held_q[d]));
        end
        if (m_tvalid[d] && m_tready[d]) begin
          check($sformatf("extra_beat_d%0d", d), 32'(exp_q[d].size() != 0), 32'd1);
          if (exp_q[d].size() != 0) begin
            check($sformatf("beat_d%0d", d), 32'(obs_of(d)), 32'(exp_q[d].pop_front()));
          end
        end
        stall_q[d] <= m_tvalid[d] && !m_tready[d];
        held_q[d]  <= obs_of(d);
      end
    end
  end

  task automatic drive_beat(input int d, input logic [7:0] data, input logic last);
    s_tvalid[d] = 1'b1;
    s_tdata[d]  = data;
    s_tlast[d]  = last;
    @(negedge clk);
    check($sformatf("s_tready_d%0d", d), 32'(s_tready[d]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Beat i of an n-beat packet is bytes[8*(n-1-i) +: 8] (first beat is leftmost).
  task automatic send_pkt(input int d, input int n, input logic [63:0] bytes,
                          input bit fwd, input bit err);
    logic [7:0] b;
    logic       last;
    for (int i = 0; i < n; i++) begin
      b    = bytes[8*(n-1-i) +: 8];
      last = (i == n - 1);
      if (fwd) exp_q[d].push_back({err & last, last, b});
      drive_beat(d, b, last);
    end
  endtask

  task automatic idle(input int d);
    s_tvalid[d] = 1'b0;
    s_tlast[d]  = 1'b0;
  endtask

  task automatic wait_drain(input int d, input string tag);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q[d].size()), 32'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int d, input int g, input int b, input int o);
    check({tag, "_good"}, good_cnt[d], 32'(g));
    check({tag, "_bad"},  bad_cnt[d],  32'(b));
    check({tag, "_ovf"},  ovf_cnt[d],  32'(o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      s_tvalid[d] = 1'b0;
      s_tlast[d]  = 1'b0;
      s_tdata[d]  = 8'h00;
      m_tready[d] = 1'b1;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("rst_m_tvalid_d%0d", d), 32'(m_tvalid[d]), 32'd0);
      check($sformatf("rst_s_tready_d%0d", d), 32'(s_tready[d]), 32'd0);
      check($sformatf("rst_terr_d%0d", d), 32'(m_terr[d]), 32'd0);
      check_cnt($sformatf("rst_d%0d", d), d, 0, 0, 0);
    end
    rst = 1'b0;
    check("rel_s_tready_before_edge", 32'(s_tready[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < N_DUT; d++)
      check($sformatf("rel_s_tready_d%0d", d), 32'(s_tready[d]), 32'd1);

    // Good packet and latency: tlast accepted at N, first beat valid after N+1
    send_pkt(0, 3, 64'h01_02_CC, 1'b1, 1'b0);
    idle(0);
    check("t1_valid_after_n", 32'(m_tvalid[0]), 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_after_n1", 32'(m_tvalid[0]), 32'd1);
    check("t1_first_data", 32'(m_tdata[0]), 32'h01);
    wait_drain(0, "t1");
    check_cnt("t1", 0, 1, 0, 0);

    // Bad packet then good packet, back to back
    send_pkt(0, 3, 64'h01_02_CD, 1'b0, 1'b0);
    send_pkt(0, 3, 64'h01_02_CC, 1'b1, 1'b0);
    idle(0);
    wait_drain(0, "t2");
    check_cnt("t2", 0, 2, 1, 0);

    // Three good packets under full stall, then random backpressure
    m_tready[0] = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(0, 3, 64'h01_02_CC, 1'b1, 1'b0);
    idle(0);
    repeat (4) @(posedge clk);
    #1;
    check("t3_stall_valid", 32'(m_tvalid[0]), 32'd1);
    check("t3_stall_data", 32'(m_tdata[0]), 32'h01);
    for (int i = 0; i < 60; i++) begin
      m_tready[0] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    m_tready[0] = 1'b1;
    wait_drain(0, "t3");
    check_cnt("t3", 0, 5, 1, 0);

    // FIFO_DEPTH=4: oversize packet dropped, then a good packet intact
    send_pkt(1, 6, 64'h10_11_12_13_14_15, 1'b0, 1'b0);
    send_pkt(1, 3, 64'h01_02_CC, 1'b1, 1'b0);
    idle(1);
    wait_drain(1, "t4a");
    check_cnt("t4a", 1, 1, 0, 1);
    // Good-CRC 5-beat packet overflows on its tlast beat; 4 beats fit exactly
    send_pkt(1, 5, 64'hFF_00_00_00_00, 1'b0, 1'b0);
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    send_pkt(1, 4, 64'hFF_00_00_00, 1'b1, 1'b0);
    idle(1);
    wait_drain(1, "t4b");
    check_cnt("t4b", 1, 2, 0, 2);

    // DROP_BAD=0: bad packet forwarded with error flag on its last beat
    send_pkt(2, 3, 64'h01_02_CD, 1'b1, 1'b1);
    send_pkt(2, 3, 64'h01_02_CC, 1'b1, 1'b0);
    idle(2);
    wait_drain(2, "t5");
    check_cnt("t5", 2, 1, 1, 0);

    // Reset mid-packet: partial data lost, counters cleared
    drive_beat(0, 8'h01, 1'b0);
    drive_beat(0, 8'h02, 1'b0);
    idle(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_m_tvalid", 32'(m_tvalid[0]), 32'd0);
    check("t6_rst_s_tready", 32'(s_tready[0]), 32'd0);
    check_cnt("t6_rst", 0, 0, 0, 0);
    check("t6_rst_ovf_d1", ovf_cnt[1], 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_partial", 32'(m_tvalid[0]), 32'd0);
    send_pkt(0, 3, 64'h01_02_CC, 1'b1, 1'b0);
    idle(0);
    wait_drain(0, "t6");
    check_cnt("t6", 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_crc_filter.md
Name: axis_crc_filter

Overview:
- Parametrised store-and-forward AXI-Stream CRC filter.
- Receives packets on AXIS_SLV_IF and computes a CRC of configurable width and polynomial over every accepted beat.
- Forwards only packets whose CRC residue is zero on AXIS_MST_IF, or forwards all packets with an error flag, depending on mode.
- Unlike the single-packet checker, it uses a packet-commit FIFO, so reception and transmission overlap without inter-packet stalls. It also handles oversized/overflow packets and keeps per-outcome statistics counters.

Parameters:
- FIFO_DEPTH, 1024: buffer depth in beats; power of two, >= 4.
- CRC_W, 8: CRC width in bits; must be <= tdata width.
- CRC_POLY, 8'h07: generator polynomial, implicit top bit, MSB-first, no reflection.
- CRC_INIT, 8'hFF: CRC register value at start of each packet; no final XOR.
- DROP_BAD, 1: 1 = discard bad packets; 0 = forward bad packets with M_TERR_O flagged.

Ports:
- CLK_I  in  1  single clock, rising edge.
- RST_I  in  1  synchronous reset, active-high.
- AXIS_SLV_IF  AXIS_Bus.slave  DW = $bits(tdata)  input stream: tvalid, tready, tdata, tlast.
- AXIS_MST_IF  AXIS_Bus.master  DW  output stream: tvalid, tready, tdata, tlast.
- M_TERR_O  out  1  qualified by master tvalid & tlast; 1 = packet CRC bad (DROP_BAD=0 only; constant 0 otherwise).
- GOOD_CNT_O  out  32  packets committed with good CRC; saturating.
- BAD_CNT_O  out  32  packets with non-zero residue; saturating.
- OVF_CNT_O  out  32  packets lost to FIFO overflow; saturating.

Behaviour:
- Reset (RST_I=1 at an edge): wr_ptr, commit_ptr and rd_ptr cleared; receive FSM goes to ST_IDLE; CRC register = CRC_INIT.
  - Slave tready=0 and master tvalid=0; tlast/tdata don't-care; M_TERR_O=0; counters=0.
  - A partial packet in flight is lost and not counted.
  - Slave tready goes 1 on the first edge after RST_I deasserts and stays 1; the block never backpressures, and overflow is handled by discard.
- CRC:
  - crc_next = f(crc_reg, tdata) over all DW bits, MSB first, bitwise LFSR with CRC_POLY.
  - crc_reg is updated on every accepted beat and reloaded with CRC_INIT after each tlast beat.
  - A packet is good iff crc_next == 0 on its tlast beat, i.e. the sender appends the CRC in the low CRC_W bits of the last word.
- Receive FSM (advances on accepted beats only):
  - ST_IDLE: on an accepted beat, write it. If tlast, resolve the packet immediately; else go to ST_PKT.
  - ST_PKT: write each beat. On tlast, resolve and go to ST_IDLE.
  - ST_DISCARD: beats are accepted and not written. On tlast, rewind wr_ptr := commit_ptr, OVF_CNT_O+1, go to ST_IDLE; CRC is not evaluated and BAD is not counted.
  - Overflow: an accepted beat arriving when wr_ptr - rd_ptr == FIFO_DEPTH is not written; the FSM goes to ST_DISCARD, or for a tlast beat performs the discard resolution in the same cycle.
  - Resolution, good: commit_ptr := wr_ptr including the last beat; GOOD+1.
  - Resolution, bad with DROP_BAD=1: wr_ptr := commit_ptr (rewind); BAD+1.
  - Resolution, bad with DROP_BAD=0: commit, store err=1 alongside the tlast beat; BAD+1.
- FIFO entry = {err, tlast, tdata}. Read side only sees committed beats (rd_ptr != commit_ptr).
- Output stage: one registered entry. It loads from the FIFO when empty or when consumed (tvalid & tready) in the same cycle. Full throughput is 1 beat/clk.
- AXIS master rules: once tvalid=1, tdata/tlast/M_TERR_O are held until tready; tvalid is never withdrawn without a handshake.
- Latency: tlast accepted at edge N (commit at N) -> first beat of that packet on master with tvalid=1 after edge N+1, given the output stage is idle.
- Simultaneous events: commit and read in the same cycle are both honoured. Free-space check uses rd_ptr before that cycle's read, which is conservative. A rewind never moves below commit_ptr, so already committed packets are never affected.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full = difference == FIFO_DEPTH.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- A packet longer than FIFO_DEPTH beats always overflows.

Test Plan:
- DW=8, defaults. Send {01,02,CC}, master tready=1 -> master outputs 01,02,CC with tlast on CC, first beat 2 edges after slave tlast; GOOD=1, BAD=0.
- Send {01,02,CD} then {01,02,CC} back-to-back -> only the second packet appears; BAD=1, GOOD=1; slave tready never drops.
- Master tready held 0 while 3 good packets arrive, then a random tready pattern -> all 9 beats delivered in order; tvalid/tdata stable while stalled; no extra beats.
- FIFO_DEPTH=4: send a 6-beat packet, then {01,02,CC} -> the 6-beat packet is discarded, OVF=1, BAD=0; the following packet is delivered intact.
- DROP_BAD=0: send {01,02,CD} -> 3 beats forwarded; M_TERR_O=1 on the CD tlast beat and 0 on a following good packet; BAD=1.
- Assert RST_I for 1 cycle after 2 beats of a packet, then send {01,02,CC} -> no partial data output; master tvalid=0 during reset; counters read 0 then GOOD=1.
